// File: rtl/cache_port_arb.sv
// cache_port_arb: shares the single-ported cache_ctrl user interface between an
// instruction-fetch read port (I) and a read/write data port (D).
//
// Each winning request is latched and issued to the controller as a one-cycle
// m_rd_en/m_wr_en pulse. m_addr/m_wdata/m_mask then stay stable until the
// access completes. Read hits and misses are counted.
//
// Ports:
//   clk, rst_x                 clock, asynchronous active-low reset
//   i_req/i_addr               I-port read request (held until i_gnt)
//   i_gnt/i_done/i_rdata       I-port accept pulse, completion pulse, read data
//   d_req/d_we/d_addr/
//   d_wdata/d_mask             D-port request (held until d_gnt)
//   d_gnt/d_done/d_rdata       D-port accept pulse, completion pulse, read data
//   m_*                        cache_ctrl user interface (m_hit is its c_oe)
//   cnt_clr, hit_cnt, miss_cnt read statistics (clear wins over increment)
//
// Configuration:
//   CACHE_ARB_RR_EN  defined   : round-robin between I and D
//                    undefined : fixed priority, D beats I
module cache_port_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_done,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_mask,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [31:0]           d_rdata,
  output logic                  m_rd_en,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_mask,
  input  logic [31:0]           m_rdata,
  input  logic                  m_busy,
  input  logic                  m_hit,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q;
  logic   owner_d_q;  // 1 = current transaction belongs to D
  logic   we_q;
  logic   pick_d;
  logic   hit_inc;
  logic   miss_inc;

`ifdef CACHE_ARB_RR_EN
  logic last_d_q;  // 1 = D won the previous arbitration

  // On contention, the port that did not win last time goes first.
  always_comb begin
    pick_d = d_req && (!i_req || !last_d_q);
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      last_d_q <= 1'b0;
    end else if (state_q == StIdle && !m_busy && (i_req || d_req)) begin
      last_d_q <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Hit/miss is only known in the ISSUE cycle, while the controller drives c_oe.
  always_comb begin
    hit_inc  = (state_q == StIssue) && !we_q && m_hit;
    miss_inc = (state_q == StIssue) && !we_q && !m_hit;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= StIdle;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      m_rd_en   <= 1'b0;
      m_wr_en   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_mask    <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      // All pulses default low; each is set for exactly one cycle below.
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      m_rd_en <= 1'b0;
      m_wr_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!m_busy && (i_req || d_req)) begin
            owner_d_q <= pick_d;
            we_q      <= pick_d && d_we;
            m_addr    <= pick_d ? d_addr : i_addr;
            m_wdata   <= pick_d ? d_wdata : 32'h0;
            m_mask    <= pick_d ? d_mask : 4'b1111;
            m_rd_en   <= !(pick_d && d_we);
            m_wr_en   <= pick_d && d_we;
            i_gnt     <= !pick_d;
            d_gnt     <= pick_d;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (!we_q && m_hit) begin
            if (owner_d_q) d_rdata <= m_rdata;
            else           i_rdata <= m_rdata;
            i_done  <= !owner_d_q;
            d_done  <= owner_d_q;
            state_q <= StResp;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!m_busy) begin
            if (!we_q) begin
              if (owner_d_q) d_rdata <= m_rdata;
              else           i_rdata <= m_rdata;
            end
            i_done  <= !owner_d_q;
            d_done  <= owner_d_q;
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
      if (miss_inc) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cache_port_arb.sv
// Directed self-checking bench for cache_port_arb. The controller side
// (m_hit, m_busy, m_rdata) is driven by hand in each scenario. Counters are
// built 4 bits wide so that the wrap case is reachable.
module tb_cache_port_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_x;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_done;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_mask;
  logic          d_gnt;
  logic          d_done;
  logic [31:0]   d_rdata;
  logic          m_rd_en;
  logic          m_wr_en;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_mask;
  logic [31:0]   m_rdata;
  logic          m_busy;
  logic          m_hit;
  logic          cnt_clr;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int n_vec;
  int n_err;

  cache_port_arb #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_x(rst_x),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_mask(m_mask), .m_rdata(m_rdata), .m_busy(m_busy), .m_hit(m_hit),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-port read hit used as stimulus for the counter scenarios.
  task automatic hit_txn(input logic use_d, input logic do_clr);
    if (use_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010; end
    else begin i_req = 1'b1; i_addr = 32'h0000_0020; end
    step();
    n_vec++;
    if ({i_gnt, d_gnt} !== {!use_d, use_d}) begin
      n_err++;
      $display("FAIL hit_txn_gnt: got %b expected %b", {i_gnt, d_gnt}, {!use_d, use_d});
    end
    i_req = 1'b0; d_req = 1'b0;
    m_hit = 1'b1; m_rdata = 32'h0BAD_F00D; cnt_clr = do_clr;
    step();
    m_hit = 1'b0; cnt_clr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    #12;
    n_vec++;
    if ({i_gnt, d_gnt, i_done, d_done, m_rd_en, m_wr_en} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %b expected 000000",
               {i_gnt, d_gnt, i_done, d_done, m_rd_en, m_wr_en});
    end
    n_vec++;
    if ({m_addr, m_wdata, m_mask} !== '0) begin
      n_err++;
      $display("FAIL reset_m_bus: got %h %h %h expected 0", m_addr, m_wdata, m_mask);
    end
    n_vec++;
    if ({i_rdata, d_rdata, hit_cnt, miss_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_data_cnt: got %h %h %h %h expected 0",
               i_rdata, d_rdata, hit_cnt, miss_cnt);
    end
    @(negedge clk);
    rst_x = 1'b1;
    step();
  endtask

  task automatic test_read_miss();
    i_req = 1'b1; i_addr = 32'h0000_0100;
    step();  // cycle 1: ISSUE
    n_vec++;
    if ({i_gnt, d_gnt, m_rd_en, m_wr_en, m_addr, m_mask} !== {4'b1010, 32'h100, 4'hF}) begin
      n_err++;
      $display("FAIL miss_issue: got %b %h %h expected 1010 00000100 f",
               {i_gnt, d_gnt, m_rd_en, m_wr_en}, m_addr, m_mask);
    end
    i_req = 1'b0; i_addr = 32'hFFFF_FFFF;
    for (int c = 2; c <= 9; c++) begin
      step();
      m_busy = (c <= 7);
      if (c == 8) m_rdata = 32'hDEAD_BEEF;
      n_vec++;
      if ({m_addr, m_rd_en, i_gnt, i_done} !== {32'h100, 1'b0, 1'b0, (c == 9)}) begin
        n_err++;
        $display("FAIL miss_cycle%0d: got addr=%h rd_en=%b gnt=%b done=%b expected %h 0 0 %b",
                 c, m_addr, m_rd_en, i_gnt, i_done, 32'h100, (c == 9));
      end
    end
    n_vec++;
    if (i_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL miss_rdata: got %h expected deadbeef", i_rdata);
    end
    m_rdata = 32'h0;
    step();  // cycle 10: IDLE
    n_vec++;
    if ({i_done, hit_cnt, miss_cnt, i_rdata} !== {1'b0, 4'd0, 4'd1, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL miss_after: got done=%b hit=%0d miss=%0d rdata=%h expected 0 0 1 deadbeef",
               i_done, hit_cnt, miss_cnt, i_rdata);
    end
  endtask

  task automatic test_read_hit();
    i_req = 1'b1; i_addr = 32'h0000_0100;
    step();  // cycle 1
    n_vec++;
    if ({i_gnt, m_rd_en, i_done} !== 3'b110) begin
      n_err++;
      $display("FAIL hit_issue: got %b expected 110", {i_gnt, m_rd_en, i_done});
    end
    i_req = 1'b0; m_hit = 1'b1; m_rdata = 32'h1234_5678;
    step();  // cycle 2
    m_hit = 1'b0; m_rdata = 32'h0;
    n_vec++;
    if ({i_done, i_rdata, hit_cnt, miss_cnt} !== {1'b1, 32'h1234_5678, 4'd1, 4'd1}) begin
      n_err++;
      $display("FAIL hit_done: got done=%b rdata=%h hit=%0d miss=%0d expected 1 12345678 1 1",
               i_done, i_rdata, hit_cnt, miss_cnt);
    end
    step();  // cycle 3
    n_vec++;
    if (i_done !== 1'b0) begin
      n_err++;
      $display("FAIL hit_done_width: got %b expected 0", i_done);
    end
  endtask

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040;
    d_wdata = 32'hA5A5_A5A5; d_mask = 4'b0011;
    step();  // cycle 1
    n_vec++;
    if ({d_gnt, i_gnt, m_wr_en, m_rd_en, m_mask, m_wdata, m_addr}
        !== {4'b1010, 4'b0011, 32'hA5A5_A5A5, 32'h40}) begin
      n_err++;
      $display("FAIL wr_issue: got %b %b %h %h expected 1010 0011 a5a5a5a5 00000040",
               {d_gnt, i_gnt, m_wr_en, m_rd_en}, m_mask, m_wdata, m_addr);
    end
    // Controller may flag c_oe on a write; that must not shortcut the write.
    d_req = 1'b0; d_wdata = 32'h0; d_mask = 4'hF; m_hit = 1'b1; m_rdata = 32'hBAD0_BAD0;
    for (int c = 2; c <= 6; c++) begin
      step();
      m_hit = 1'b0;
      m_busy = (c <= 4);
      n_vec++;
      if ({m_wdata, m_mask, m_addr, m_wr_en, d_done}
          !== {32'hA5A5_A5A5, 4'b0011, 32'h40, 1'b0, (c == 6)}) begin
        n_err++;
        $display("FAIL wr_cycle%0d: got %h %b %h we=%b done=%b expected a5a5a5a5 0011 40 0 %b",
                 c, m_wdata, m_mask, m_addr, m_wr_en, d_done, (c == 6));
      end
    end
    m_rdata = 32'h0;
    step();  // cycle 7
    n_vec++;
    if ({d_done, d_rdata, hit_cnt, miss_cnt} !== {1'b0, 32'h0, 4'd1, 4'd1}) begin
      n_err++;
      $display("FAIL wr_after: got done=%b rdata=%h hit=%0d miss=%0d expected 0 0 1 1",
               d_done, d_rdata, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_abort();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
    step();  // ISSUE
    d_req = 1'b0;
    step();  // first WAIT
    m_busy = 1'b1;
    step();  // still WAIT
    #2;
    rst_x = 1'b0;
    #1;
    n_vec++;
    if ({i_gnt, d_gnt, i_done, d_done, m_rd_en, m_wr_en} !== 6'b0) begin
      n_err++;
      $display("FAIL abort_pulses: got %b expected 000000",
               {i_gnt, d_gnt, i_done, d_done, m_rd_en, m_wr_en});
    end
    n_vec++;
    if ({m_addr, m_wdata, m_mask, i_rdata, d_rdata, hit_cnt, miss_cnt} !== '0) begin
      n_err++;
      $display("FAIL abort_regs: got addr=%h mask=%h hit=%0d miss=%0d expected all 0",
               m_addr, m_mask, hit_cnt, miss_cnt);
    end
    m_busy = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      n_vec++;
      if ({i_gnt, d_gnt, i_done, d_done} !== 4'b0) begin
        n_err++;
        $display("FAIL abort_quiet%0d: got %b expected 0000", c, {i_gnt, d_gnt, i_done, d_done});
      end
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_d;
    logic       win_d;
    int         k;
`ifdef CACHE_ARB_RR_EN
    exp_d = 4'b0101;  // bit r = 1 when D should win round r: D, I, D, I
`else
    exp_d = 4'b1111;
`endif
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    for (int r = 0; r < 4; r++) begin
      k = 0;
      do begin
        step();
        k++;
      end while (!(i_gnt || d_gnt) && k < 8);
      win_d = exp_d[r];
      n_vec++;
      if ({i_gnt, d_gnt, m_addr} !== {!win_d, win_d, (win_d ? 32'h300 : 32'h200)}) begin
        n_err++;
        $display("FAIL arb_gnt%0d: got i=%b d=%b addr=%h expected i=%b d=%b",
                 r, i_gnt, d_gnt, m_addr, !win_d, win_d);
      end
      if (win_d) d_req = 1'b0;
      else       i_req = 1'b0;
      m_hit = 1'b1; m_rdata = 32'h5000 + r;
      step();  // RESP
      m_hit = 1'b0;
      n_vec++;
      if ({i_done, d_done, (win_d ? d_rdata : i_rdata)} !== {!win_d, win_d, 32'h5000 + r}) begin
        n_err++;
        $display("FAIL arb_done%0d: got i=%b d=%b rdata=%h expected i=%b d=%b %h",
                 r, i_done, d_done, (win_d ? d_rdata : i_rdata), !win_d, win_d, 32'h5000 + r);
      end
      if (r < 3) begin
        if (win_d) d_req = 1'b1;
        else       i_req = 1'b1;
      end else begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    step();  // back to IDLE
    n_vec++;
    if (hit_cnt !== 4'd4) begin
      n_err++;
      $display("FAIL arb_hits: got %0d expected 4", hit_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_vec++;
    if ({hit_cnt, miss_cnt} !== 8'h00) begin
      n_err++;
      $display("FAIL cnt_clr_idle: got %h %h expected 0 0", hit_cnt, miss_cnt);
    end
    for (int n = 0; n < 15; n++) hit_txn(1'b0, 1'b0);
    n_vec++;
    if (hit_cnt !== 4'hF) begin
      n_err++;
      $display("FAIL cnt_max: got %h expected f", hit_cnt);
    end
    hit_txn(1'b1, 1'b0);
    n_vec++;
    if (hit_cnt !== 4'h0) begin
      n_err++;
      $display("FAIL cnt_wrap: got %h expected 0", hit_cnt);
    end
    hit_txn(1'b0, 1'b0);
    n_vec++;
    if (hit_cnt !== 4'h1) begin
      n_err++;
      $display("FAIL cnt_after_wrap: got %h expected 1", hit_cnt);
    end
    hit_txn(1'b0, 1'b1);
    n_vec++;
    if ({hit_cnt, miss_cnt} !== 8'h00) begin
      n_err++;
      $display("FAIL cnt_clr_vs_hit: got %h %h expected 0 0", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_x = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_mask = 4'hF;
    m_rdata = '0; m_busy = 1'b0; m_hit = 1'b0; cnt_clr = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write();
    test_reset_abort();
    test_arbitration();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
